// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for the nibble-serial adder: state encoding and slice width.
package nibble_add_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_add_seq_add4.sv
// nibble_add4: combinational 4-bit ripple-carry slice built from full-adder cells.
module nibble_add4
  import nibble_add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a4,
  input  logic [SLICE_W-1:0] b4,
  input  logic               ci,
  output logic [SLICE_W-1:0] s4,
  output logic               co
);

  logic [SLICE_W:0] c_s;

  assign c_s[0] = ci;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign s4[i]    = a4[i] ^ b4[i] ^ c_s[i];
    assign c_s[i+1] = (a4[i] & b4[i]) | (c_s[i] & (a4[i] ^ b4[i]));
  end

  assign co = c_s[SLICE_W];

endmodule

// File: rtl/nibble_add_seq.sv
// Wide adder that reuses one 4-bit slice, one nibble per clock, LSB nibble first.
// Optional signed-overflow output enabled by NIBBLE_ADD_SEQ_OVF_EN.
module nibble_add_seq
  import nibble_add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_ADD_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDXW   = $clog2(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_t             state_r;
  logic [WIDTH-1:0]   opa_r;
  logic [WIDTH-1:0]   opb_r;
  logic               carry_r;
  logic [IDXW-1:0]    idx_r;
  logic [SLICE_W-1:0] slice_a_s;
  logic [SLICE_W-1:0] slice_b_s;
  logic [SLICE_W-1:0] slice_sum_s;
  logic               slice_co_s;

  assign slice_a_s = opa_r[idx_r*SLICE_W +: SLICE_W];
  assign slice_b_s = opb_r[idx_r*SLICE_W +: SLICE_W];

  nibble_add4 u_add4 (
    .a4 (slice_a_s),
    .b4 (slice_b_s),
    .ci (carry_r),
    .s4 (slice_sum_s),
    .co (slice_co_s)
  );

`ifdef NIBBLE_ADD_SEQ_OVF_EN
  // Carry into the MSB recovered from the last slice's top sum bit.
  logic msb_cin_s;
  assign msb_cin_s = opa_r[WIDTH-1] ^ opb_r[WIDTH-1] ^ slice_sum_s[SLICE_W-1];
`endif

  // Controller FSM, operand capture, nibble index, carry and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      done_valid  <= 1'b0;
      sum         <= {WIDTH{1'b0}};
      cout        <= 1'b0;
      carry_r     <= 1'b0;
      idx_r       <= {IDXW{1'b0}};
      opa_r       <= {WIDTH{1'b0}};
      opb_r       <= {WIDTH{1'b0}};
`ifdef NIBBLE_ADD_SEQ_OVF_EN
      ovf         <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          start_ready <= 1'b1;
          if (start_valid) begin
            opa_r       <= a;
            opb_r       <= b;
            carry_r     <= cin;
            idx_r       <= {IDXW{1'b0}};
            sum         <= {WIDTH{1'b0}};
            start_ready <= 1'b0;
            busy        <= 1'b1;
            state_r     <= RUN;
          end
        end
        RUN: begin
          sum[idx_r*SLICE_W +: SLICE_W] <= slice_sum_s;
          carry_r <= slice_co_s;
          if (idx_r == LAST_IDX) begin
            cout       <= slice_co_s;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
            ovf        <= msb_cin_s ^ slice_co_s;
`endif
            idx_r      <= {IDXW{1'b0}};
            busy       <= 1'b0;
            done_valid <= 1'b1;
            state_r    <= DONE;
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        DONE: begin
          // The handshake returns to IDLE only; a pending command waits one cycle.
          if (done_ready) begin
            done_valid  <= 1'b0;
            start_ready <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          start_ready <= 1'b1;
          busy        <= 1'b0;
          done_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq (WIDTH=16); covers ovf when NIBBLE_ADD_SEQ_OVF_EN is defined.
module tb_nibble_add_seq;

  localparam int W      = 16;
  localparam int NSLICE = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_ovf;

  nibble_add_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .busy        (busy),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .sum         (sum),
    .cout        (cout)
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer arithmetic on the full operands.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    longint unsigned u;
    longint          s;
    u = longint'(ta) + longint'(tb) + longint'(tc);
    exp_sum  = u[W-1:0];
    exp_cout = u[W];
    s = longint'($signed(ta)) + longint'($signed(tb)) + longint'(tc);
    exp_ovf = (s > longint'(2**(W-1) - 1)) || (s < -longint'(2**(W-1)));
  endtask

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    model(ta, tb, tc);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start_valid = 1'b1;
    chk("start_ready_idle", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("start_ready_run", 32'(start_ready), 32'd0);
  endtask

  task automatic finish(input int stall, input bit keep_start,
                        input logic [W-1:0] na, input logic [W-1:0] nb, input logic nc);
    int lat;
    lat = 0;
    while (!done_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(NSLICE));
    chk("sum", 32'(sum), 32'(exp_sum));
    chk("cout", 32'(cout), 32'(exp_cout));
    chk("busy_done", 32'(busy), 32'd0);
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    chk("ovf", 32'(ovf), 32'(exp_ovf));
`endif
    if (keep_start) begin
      @(negedge clk);
      a = na; b = nb; cin = nc; start_valid = 1'b1;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(done_valid), 32'd1);
      chk("hold_sum", 32'(sum), 32'(exp_sum));
      chk("hold_cout", 32'(cout), 32'(exp_cout));
      chk("hold_busy", 32'(busy), 32'd0);
    end
    @(negedge clk);
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    chk("valid_drop", 32'(done_valid), 32'd0);
    chk("ready_back", 32'(start_ready), 32'd1);
    chk("idle_not_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #1;
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // done_ready outside DONE must do nothing
    @(negedge clk); done_ready = 1'b1;
    @(posedge clk); #1; done_ready = 1'b0;
    chk("stray_done_ready", 32'(done_valid), 32'd0);

    issue(16'h1234, 16'h4321, 1'b0); finish(0, 1'b0, '0, '0, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0); finish(0, 1'b0, '0, '0, 1'b0);
    issue(16'h00FF, 16'h0000, 1'b1); finish(1, 1'b0, '0, '0, 1'b0);

    // Back-pressure with a new command pending during DONE
    issue(16'hABCC, 16'h0001, 1'b0);
    chk("bp_model", 32'(exp_sum), 32'h0000ABCD);
    finish(5, 1'b1, 16'h1111, 16'h2222, 1'b1);
    issue(16'h1111, 16'h2222, 1'b1); finish(0, 1'b0, '0, '0, 1'b0);

    // Reset during the second RUN cycle
    issue(16'h5A5A, 16'hA5A5, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("abort_start_ready", 32'(start_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done_valid), 32'd0);
    end
    issue(16'h0002, 16'h0003, 1'b0); finish(0, 1'b0, '0, '0, 1'b0);

    issue(16'h7FFF, 16'h0001, 1'b0); finish(0, 1'b0, '0, '0, 1'b0);
    issue(16'h8000, 16'h8000, 1'b0); finish(0, 1'b0, '0, '0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      finish(int'($urandom_range(0, 3)), 1'b0, '0, '0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
